// File: rtl/bus_cycle_gen_pkg.sv
// Shared types and control-vector bit map for the bus-cycle sequencer.
// Optional feature macro used by this slice: RDY_SYNC_EN.
package ctl_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_STROBE,
        ST_TAIL,
        ST_HOLD
    } state_t;

    localparam int unsigned CTL_SYNC  = 0;
    localparam int unsigned CTL_STVAL = 1;
    localparam int unsigned CTL_DBIN  = 2;
    localparam int unsigned CTL_WR    = 3;
    localparam int unsigned CTL_IOQ   = 4;
    localparam int unsigned CTL_W     = 5;

    // Control vector presented while the sequencer sits in a given state.
    function automatic logic [CTL_W-1:0] ctl_for(state_t st, logic we, logic io);
        logic [CTL_W-1:0] v;
        v = '0;
        case (st)
            ST_SYNC: begin
                v[CTL_SYNC]  = 1'b1;
                v[CTL_STVAL] = 1'b1;
                v[CTL_IOQ]   = io;
            end
            ST_STROBE: begin
                v[CTL_DBIN] = !we;
                v[CTL_WR]   = we;
                v[CTL_IOQ]  = io;
            end
            ST_TAIL: v[CTL_IOQ] = io;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/bus_cycle_gen_if.sv
// CPU request / external bus / DMA signal bundle for bus_cycle_gen.
// Optional feature macro used by this slice: RDY_SYNC_EN.
interface bus_cycle_gen_if;

    logic                          cpu_start;
    logic                          cpu_we;
    logic                          cpu_io;
    logic [3:0]                    wait_states;
    logic                          bus_rdy;
    logic                          dma_hold;
    logic [ctl_bus_pkg::CTL_W-1:0] ctl_out;
    logic                          hold_ack;
    logic                          busy;
    logic                          cpu_done;
    logic                          cpu_err;

    modport master (
        output cpu_start, cpu_we, cpu_io, wait_states, bus_rdy, dma_hold,
        input  ctl_out, hold_ack, busy, cpu_done, cpu_err
    );

    modport slave (
        input  cpu_start, cpu_we, cpu_io, wait_states, bus_rdy, dma_hold,
        output ctl_out, hold_ack, busy, cpu_done, cpu_err
    );

endinterface

// File: rtl/bus_cycle_gen_rdy_sync.sv
// Two-flop synchronizer for the external ready line.
// Only present when RDY_SYNC_EN is defined.
`ifdef RDY_SYNC_EN
module rdy_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`endif

// File: rtl/bus_cycle_gen.sv
// Bus-cycle sequencer: SYNC -> STROBE (+waits/timeout) -> TAIL, with DMA hold.
// RDY_SYNC_EN defined inserts a 2-flop synchronizer on bus_rdy.
module bus_cycle_gen
    import ctl_bus_pkg::*;
#(
    parameter int unsigned SYNC_CYC = 1,
    parameter int unsigned HOLD_CYC = 1,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic            clock,
    input  logic            reset,
    bus_cycle_gen_if.slave  bus
);

    localparam int unsigned PH_MAX = (SYNC_CYC > HOLD_CYC) ? SYNC_CYC : HOLD_CYC;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

    state_t             r_state;
    logic [CTL_W-1:0]   r_ctl;
    logic               r_hold_ack;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               r_err_flag;
    logic               r_we;
    logic               r_io;
    logic [3:0]         r_wcnt;
    logic [TO_W-1:0]    r_tcnt;
    logic [PH_W-1:0]    r_phase;
    logic               w_rdy;

`ifdef RDY_SYNC_EN
    rdy_sync u_rdy_sync (
        .i_clk (clock),
        .i_rst (reset),
        .i_d   (bus.bus_rdy),
        .o_q   (w_rdy)
    );
`else
    assign w_rdy = bus.bus_rdy;
`endif

    // Outputs are registered alongside the state: each transition loads the
    // control vector belonging to the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ctl      <= '0;
            r_hold_ack <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_flag <= 1'b0;
            r_we       <= 1'b0;
            r_io       <= 1'b0;
            r_wcnt     <= '0;
            r_tcnt     <= '0;
            r_phase    <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.dma_hold) begin
                        r_state    <= ST_HOLD;
                        r_hold_ack <= 1'b1;
                        r_ctl      <= '0;
                    end else if (bus.cpu_start) begin
                        r_state    <= ST_SYNC;
                        r_we       <= bus.cpu_we;
                        r_io       <= bus.cpu_io;
                        r_wcnt     <= bus.wait_states;
                        r_tcnt     <= '0;
                        r_err_flag <= 1'b0;
                        r_phase    <= PH_W'(SYNC_CYC - 1);
                        r_busy     <= 1'b1;
                        r_ctl      <= ctl_for(ST_SYNC, bus.cpu_we, bus.cpu_io);
                    end
                end
                ST_SYNC: begin
                    if (r_phase == '0) begin
                        r_state <= ST_STROBE;
                        r_ctl   <= ctl_for(ST_STROBE, r_we, r_io);
                    end else begin
                        r_phase <= r_phase - 1'b1;
                    end
                end
                ST_STROBE: begin
                    if (r_wcnt != '0) begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end else if (w_rdy) begin
                        r_state <= ST_TAIL;
                        r_phase <= PH_W'(HOLD_CYC - 1);
                        r_ctl   <= ctl_for(ST_TAIL, r_we, r_io);
                    end else if (r_tcnt == TO_W'(TIMEOUT)) begin
                        r_state    <= ST_TAIL;
                        r_err_flag <= 1'b1;
                        r_phase    <= PH_W'(HOLD_CYC - 1);
                        r_ctl      <= ctl_for(ST_TAIL, r_we, r_io);
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                ST_TAIL: begin
                    if (r_phase == '0) begin
                        r_state    <= ST_IDLE;
                        r_ctl      <= '0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_err      <= r_err_flag;
                        r_err_flag <= 1'b0;
                    end else begin
                        r_phase <= r_phase - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!bus.dma_hold) begin
                        r_state    <= ST_IDLE;
                        r_hold_ack <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_ctl      <= '0;
                    r_busy     <= 1'b0;
                    r_hold_ack <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ctl_out  = r_ctl;
    assign bus.hold_ack = r_hold_ack;
    assign bus.busy     = r_busy;
    assign bus.cpu_done = r_done;
    assign bus.cpu_err  = r_err;

endmodule

// File: doc/bus_cycle_gen.md
# bus_cycle_gen

Front-end bus-cycle sequencer for the SBC's external control bus. It turns single-cycle CPU cycle requests into timed control-strobe sequences on a 5-bit active-high control vector: sync/status, then read or write strobe, wait states, then trailing hold. It feeds the control-bus mux directly: `ctl_out` drives the mux control input and `hold_ack` drives the mux select, so the bus is zeroed during DMA hold.

## Interface
Parameters:
- SYNC_CYC, 1: cycles in SYNC state (≥1)
- HOLD_CYC, 1: cycles in TAIL state (≥1)
- TIMEOUT, 255: max post-wait cycles with rdy low before abort (≥1)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_start  in  1  one-cycle pulse requesting a bus cycle
- cpu_we  in  1  1 = write, 0 = read (sampled with cpu_start)
- cpu_io  in  1  1 = I/O cycle, 0 = memory (sampled with cpu_start)
- wait_states  in  4  programmed wait count (sampled with cpu_start)
- bus_rdy  in  1  external ready, active-high
- dma_hold  in  1  DMA bus request
- ctl_out  out  5  [0] SYNC, [1] STVAL, [2] DBIN, [3] WR, [4] IOQ; all active-high, 0 = idle
- hold_ack  out  1  bus granted to DMA; mux select
- busy  out  1  cycle in progress (state ≠ IDLE/HOLD)
- cpu_done  out  1  one-cycle completion pulse
- cpu_err  out  1  one-cycle timeout pulse, coincident with cpu_done

## Operation
- States: IDLE, SYNC, STROBE, TAIL, HOLD.
- IDLE: ctl_out = 0.
  - dma_hold = 1 → HOLD. This has priority over a simultaneous cpu_start, which is dropped.
  - Else cpu_start = 1 → SYNC. Latch we, io and wait_states.
- cpu_start outside IDLE is ignored. There is no queueing.
- SYNC: SYNC = STVAL = 1, IOQ = io. Lasts SYNC_CYC cycles, then → STROBE.
- STROBE: DBIN = !we, WR = we, IOQ = io.
  - Wait counter loads wait_states on entry and decrements each cycle to 0.
  - Exit to TAIL when counter == 0 and rdy == 1.
  - Once counter == 0 with rdy == 0, the timeout counter increments each cycle. On reaching TIMEOUT → TAIL with err flag set.
- TAIL: strobes off, IOQ = io. Lasts HOLD_CYC cycles, then → IDLE. cpu_done pulses in the first IDLE cycle, plus cpu_err if the err flag is set.
- HOLD: ctl_out = 0, hold_ack = 1. When dma_hold = 0 → IDLE; hold_ack deasserts in that IDLE cycle.
- dma_hold mid-cycle does not abort the cycle; it is serviced at the next IDLE.
- All outputs are registered.

## Timing
- Reset: state IDLE; ctl_out = 0, hold_ack = 0, busy = 0, cpu_done = 0, cpu_err = 0; counters and latches cleared. Reset mid-cycle forces these values on the next edge with no trailing strobes.
- With defaults, rdy = 1, wait_states = N, cpu_start high in cycle 0:
  - SYNC in cycle 1.
  - STROBE in cycles 2..2+N.
  - TAIL in cycle 3+N.
  - cpu_done in cycle 4+N, and a new cpu_start is accepted in that same cycle.
- hold_ack rises one cycle after dma_hold is sampled high in IDLE.
- Counter widths: 4 bits for the wait counter; $clog2(TIMEOUT+1) for the timeout counter. No wrap: both counters saturate at their terminal values.

## Configuration
- RDY_SYNC_EN defined: bus_rdy passes through a 2-flop synchronizer before use, adding 2 cycles of rdy latency. A rdy drop is seen 2 cycles late.
- RDY_SYNC_EN undefined: bus_rdy is used directly. It must be synchronous to clock.

## Structure
- Package ctl_bus_pkg holds:
  - state enum;
  - bit indices CTL_SYNC = 0, CTL_STVAL = 1, CTL_DBIN = 2, CTL_WR = 3, CTL_IOQ = 4;
  - CTL_W = 5.
- One sub-module, rdy_sync (2-flop synchronizer), instantiated only under RDY_SYNC_EN.

## Test plan
- Read, N = 0, rdy = 1, cpu_start in cycle 0 → ctl_out = 5'b00011 in cycle 1, 5'b00100 in cycle 2, 5'b00000 in cycle 3, cpu_done in cycle 4.
- I/O write, N = 3 → WR|IOQ = 5'b11000 for cycles 2–5, IOQ alone in cycle 6, cpu_done in cycle 7.
- Read, N = 0, rdy held low with TIMEOUT = 4 → DBIN high for 5 cycles, then cpu_done and cpu_err both high in the same cycle.
- dma_hold and cpu_start together in IDLE → hold_ack = 1 next cycle, no SYNC ever, start dropped. After dma_hold falls, hold_ack = 0 one cycle later.
- reset asserted during STROBE → next cycle all outputs 0, state IDLE. A cpu_start after reset completes a normal cycle.
- With RDY_SYNC_EN: rdy rises in cycle 4 of a N = 0 read → STROBE exits after cycle 6, cpu_done in cycle 8.
